tmod_master: RTL
================

# tmod_master

Bus initiator for the temperature-monitor command bus. It accepts one command at a time from a host-side request port, drives op/operand onto the tmod bus, and waits for the slave's handshake. For read-type ops it captures the returned data. It also tracks the slave's temperature status, raising a sticky alarm and a change strobe.

## Interface
- DTYPE, logic [7:0]: operand and read-data type.
- TIMEOUT_CYCLES, 64: cycles allowed from acceptance to completion. Range 2..255.
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  host has a command.
- cmd_ready  out  1  master is idle and can take a command.
- cmd_op  in  4  TMOD_OP code.
- cmd_opnd  in  8  operand.
- rsp_valid  out  1  one-cycle completion strobe.
- rsp_data  out  8  read data (0 for write-type ops).
- rsp_err  out  1  completion was a timeout.
- bus_req  out  1  command strobe to slave.
- bus_op  out  4  op to slave.
- bus_opnd  out  8  operand to slave.
- bus_ready  in  1  slave can accept.
- bus_valid  in  1  slave read data valid.
- bus_data  in  8  slave read data.
- bus_status  in  2  TMOD_STATUS from slave.
- alarm  out  1  sticky: set when status goes HIGH or LOW.
- alarm_clr  in  1  clears alarm.
- status_chg  out  1  one-cycle strobe on any bus_status change.

## Operation
- Op classes:
  - Write: RESET=0, SET_FRQ=1, SET_HIGH_TEMP=2, SET_LOW_TEMP=3, NOOP=8..15.
  - Read: OUT_MAX=4, OUT_MIN=5, OUT_ADDR=6, OUT_AVG=7.
- FSM states: IDLE, ISSUE, WAIT_DROP, WAIT_DONE, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, register op/opnd and go to ISSUE.
- ISSUE:
  - bus_req=1; bus_op/bus_opnd held from the registers.
  - When bus_ready=1 in the same cycle, the command is accepted: clear the timeout counter and go to WAIT_DROP.
  - Otherwise stay in ISSUE with req held.
- WAIT_DROP:
  - Write op: go to WAIT_DONE.
  - Read op: if bus_valid=1, capture bus_data and go to RESP; otherwise go to WAIT_DONE.
- WAIT_DONE:
  - Write op completes when bus_ready=1.
  - Read op completes when bus_valid=1; data is captured from bus_data in that same cycle.
  - Go to RESP on completion.
- RESP: rsp_valid=1 for one cycle, then back to IDLE. There is no host backpressure on the response.
- bus_op and bus_opnd hold their values until the next ISSUE. bus_req is high only in ISSUE.
- Status monitor:
  - bus_status is registered; status_chg = (registered value differs from previous).
  - alarm is set when the new status is HIGH or LOW.
  - If alarm_clr and a set event occur in the same cycle, set wins.
- Reset values: every output 0 except cmd_ready=1. Internal status register = OK. FSM = IDLE.
- Reset mid-transaction: the transaction is abandoned with no response.

## Timing
- Command capture: cmd_valid&cmd_ready at edge N → bus_req=1 from cycle N+1.
- Minimum write latency, cmd accept to rsp_valid: 4 cycles, given bus_ready is held high.
- Minimum read latency: 3 cycles, given bus_valid=1 in the cycle after acceptance.
- rsp_data:
  - Read op: holds the captured byte until the next RESP.
  - Write op: 0.
- status_chg and alarm assert 1 cycle after the bus_status change.

## Configuration
- TMOD_MASTER_TIMEOUT_EN defined:
  - An 8-bit counter runs in WAIT_DROP and WAIT_DONE.
  - When it reaches TIMEOUT_CYCLES: go to RESP with rsp_err=1 and rsp_data=0.
  - ISSUE is not covered by the timeout.
- Undefined: no counter; rsp_err is tied to 0; the master waits indefinitely.

## Structure
- Shared package tmod_pkg holds:
  - the TMOD_OP enum (4-bit, codes above);
  - the TMOD_STATUS enum (2-bit: OK=0, HIGH=1, LOW=2);
  - an is_read_op() function.
- The slave imports the same package.
- Sub-module tmod_status_mon holds the status register, change detect and sticky alarm. The FSM stays in tmod_master.

## Test plan
- SET_HIGH_TEMP opnd 0x50, slave ready=1 → bus_req 1 cycle with op=2, opnd=0x50; rsp_valid with rsp_data=0, rsp_err=0.
- OUT_MAX, slave drives valid with data 0x3C two cycles after accept → rsp_valid, rsp_data=0x3C.
- bus_ready low for 5 cycles during ISSUE → bus_req and op held for all 5 cycles, exactly one acceptance.
- With TMOD_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=8: OUT_AVG with valid never asserted → rsp_err=1, rsp_data=0, then cmd_ready=1.
- bus_status OK→HIGH→OK, then alarm_clr → status_chg pulses twice, alarm stays 1 until clr. Clr coincident with a LOW event → alarm stays 1.
- Assert reset while in WAIT_DONE → no rsp_valid, cmd_ready=1 and bus_req=0 immediately, alarm=0.

Source files
------------

// File: rtl/tmod_pkg.sv
// Shared definitions for the temperature-monitor command bus (master and slave).
// Op codes, status codes, master FSM states and op classification helpers.
package tmod_pkg;

    typedef enum logic [3:0] {
        TMOD_RESET         = 4'd0,
        TMOD_SET_FRQ       = 4'd1,
        TMOD_SET_HIGH_TEMP = 4'd2,
        TMOD_SET_LOW_TEMP  = 4'd3,
        TMOD_OUT_MAX       = 4'd4,
        TMOD_OUT_MIN       = 4'd5,
        TMOD_OUT_ADDR      = 4'd6,
        TMOD_OUT_AVG       = 4'd7,
        TMOD_NOOP          = 4'd8
    } tmod_op_e;

    typedef enum logic [1:0] {
        TMOD_OK   = 2'd0,
        TMOD_HIGH = 2'd1,
        TMOD_LOW  = 2'd2
    } tmod_status_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_DROP = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_RESP      = 3'd4
    } tmod_state_e;

    // Read-type ops are exactly codes 4..7; 8..15 are NOOPs and behave as writes.
    function automatic logic is_read_op(input logic [3:0] op);
        return (op[3:2] == 2'b01);
    endfunction

    function automatic logic is_alarm_status(input logic [1:0] status);
        return (status == TMOD_HIGH) || (status == TMOD_LOW);
    endfunction

endpackage

// File: rtl/tmod_status_mon.sv
// Slave status tracker: registers bus_status, strobes on any change and keeps a
// sticky alarm that is set on entry to HIGH/LOW and cleared by i_alarm_clr.
module tmod_status_mon
    import tmod_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] i_status,
    input  logic       i_alarm_clr,
    output logic       o_status_chg,
    output logic       o_alarm
);

    logic [1:0] r_status;
    logic       r_status_chg;
    logic       r_alarm;
    logic       w_change;
    logic       w_set;

    assign w_change = (i_status != r_status);
    assign w_set    = w_change && is_alarm_status(i_status);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_status     <= TMOD_OK;
            r_status_chg <= 1'b0;
            r_alarm      <= 1'b0;
        end else begin
            r_status     <= i_status;
            r_status_chg <= w_change;
            // A set event in the same cycle as a clear keeps the alarm raised.
            if (w_set) begin
                r_alarm <= 1'b1;
            end else if (i_alarm_clr) begin
                r_alarm <= 1'b0;
            end
        end
    end

    assign o_status_chg = r_status_chg;
    assign o_alarm      = r_alarm;

endmodule

// File: rtl/tmod_master.sv
// tmod bus initiator: one host command at a time, issue/handshake FSM, status monitor.
// Optional completion timeout enabled by defining TMOD_MASTER_TIMEOUT_EN.
module tmod_master
    import tmod_pkg::*;
#(
    parameter type DTYPE          = logic [7:0],
    parameter int  TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_op,
    input  DTYPE       cmd_opnd,
    output logic       rsp_valid,
    output DTYPE       rsp_data,
    output logic       rsp_err,
    output logic       bus_req,
    output logic [3:0] bus_op,
    output DTYPE       bus_opnd,
    input  logic       bus_ready,
    input  logic       bus_valid,
    input  DTYPE       bus_data,
    input  logic [1:0] bus_status,
    output logic       alarm,
    input  logic       alarm_clr,
    output logic       status_chg,
    output logic [2:0] dbg_state
);

    generate
        if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
            $error("tmod_master: TIMEOUT_CYCLES must be in 2..255");
        end
    endgenerate

    tmod_state_e r_state;
    logic [3:0]  r_op;
    DTYPE        r_opnd;
    DTYPE        r_rsp_data;
    logic        r_cmd_ready;
    logic        r_bus_req;
    logic        r_rsp_valid;

    logic        w_is_read;
    logic        w_done;
    DTYPE        w_done_data;
    logic        w_timeout;

    assign w_is_read   = is_read_op(r_op);
    assign w_done      = w_is_read ? bus_valid : bus_ready;
    assign w_done_data = w_is_read ? bus_data : '0;

`ifdef TMOD_MASTER_TIMEOUT_EN
    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);

    logic [7:0] r_to_cnt;
    logic       r_rsp_err;

    // Counts every cycle spent in WAIT_DROP/WAIT_DONE; ISSUE stalls are not timed.
    assign w_timeout = ((r_to_cnt + 8'd1) == TO_LIMIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_to_cnt <= 8'd0;
        end else if (r_state == ST_ISSUE && bus_ready) begin
            r_to_cnt <= 8'd0;
        end else if (r_state == ST_WAIT_DROP || r_state == ST_WAIT_DONE) begin
            r_to_cnt <= r_to_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rsp_err <= 1'b0;
        end else begin
            r_rsp_err <= (r_state == ST_WAIT_DONE) && !w_done && w_timeout;
        end
    end

    assign rsp_err = r_rsp_err;
`else
    assign w_timeout = 1'b0;
    assign rsp_err   = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_op        <= 4'd0;
            r_opnd      <= '0;
            r_cmd_ready <= 1'b1;
            r_bus_req   <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_op        <= cmd_op;
                        r_opnd      <= cmd_opnd;
                        r_cmd_ready <= 1'b0;
                        r_bus_req   <= 1'b1;
                        r_state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (bus_ready) begin
                        r_bus_req <= 1'b0;
                        r_state   <= ST_WAIT_DROP;
                    end
                end
                ST_WAIT_DROP: begin
                    // A fast slave may return read data in the cycle right after acceptance.
                    if (w_is_read && bus_valid) begin
                        r_rsp_data  <= bus_data;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end else begin
                        r_state <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (w_done) begin
                        r_rsp_data  <= w_done_data;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end else if (w_timeout) begin
                        r_rsp_data  <= '0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_cmd_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_cmd_ready <= 1'b1;
                    r_bus_req   <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    tmod_status_mon u_status_mon (
        .clk          (clk),
        .reset        (reset),
        .i_status     (bus_status),
        .i_alarm_clr  (alarm_clr),
        .o_status_chg (status_chg),
        .o_alarm      (alarm)
    );

    assign cmd_ready = r_cmd_ready;
    assign bus_req   = r_bus_req;
    assign bus_op    = r_op;
    assign bus_opnd  = r_opnd;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign dbg_state = r_state;

endmodule
